// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, waits for lock with a timeout and
// bounded retries, debounces lock, then releases the downstream system reset.
// Optional build macro LOCK_LOSS_RECOVER_EN: when defined, loss of lock in RUN
// re-pulses the PLL and consumes a retry; otherwise RUN falls back to WAIT_LOCK.
module pll_lock_supervisor #(
   parameter int unsigned RST_PULSE_CYC    = 27,
   parameter int unsigned LOCK_TIMEOUT_CYC = 27000,
   parameter int unsigned LOCK_STABLE_CYC  = 2700,
   parameter int unsigned MAX_RETRY        = 7
) (
   input  logic       clkin,
   input  logic       reset,
   input  logic       lock_in,
   output logic       pll_reset,
   output logic       sys_reset,
   output logic       locked,
   output logic       fault,
   output logic [3:0] retry_count
);

   localparam int unsigned MAX_AB  = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ? RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
   localparam int unsigned MAX_CYC = (MAX_AB > LOCK_STABLE_CYC) ? MAX_AB : LOCK_STABLE_CYC;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
   localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_PLL_RST,
      S_WAIT_LOCK,
      S_STABLE,
      S_RUN,
      S_FAULT
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       retry_q, retry_d;
   logic             lock_meta_q, lock_s_q;
   logic             pll_reset_q, sys_reset_q, locked_q, fault_q;

   // Two-flop synchronizer bringing the asynchronous PLL lock into clkin.
   always_ff @(posedge clkin) begin
      if (reset) begin
         lock_meta_q <= 1'b0;
         lock_s_q    <= 1'b0;
      end else begin
         lock_meta_q <= lock_in;
         lock_s_q    <= lock_meta_q;
      end
   end

   // Next-state, counter and retry decisions for the supervisor FSM.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      retry_d = retry_q;
      unique case (state_q)
         S_PLL_RST: begin
            if (cnt_q == RST_LAST) begin
               state_d = S_WAIT_LOCK;
               cnt_d   = '0;
            end
         end
         S_WAIT_LOCK: begin
            // Lock takes priority over a timeout landing in the same cycle.
            if (lock_s_q) begin
               state_d = S_STABLE;
               cnt_d   = '0;
            end else if (cnt_q == TIMEOUT_LAST) begin
               cnt_d = '0;
               if (retry_q == RETRY_MAX) begin
                  state_d = S_FAULT;
               end else begin
                  state_d = S_PLL_RST;
                  retry_d = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
               end
            end
         end
         S_STABLE: begin
            if (!lock_s_q) begin
               state_d = S_WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            cnt_d = '0;
            if (!lock_s_q) begin
`ifdef LOCK_LOSS_RECOVER_EN
               if (retry_q == RETRY_MAX) begin
                  state_d = S_FAULT;
               end else begin
                  state_d = S_PLL_RST;
                  retry_d = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
               end
`else
               state_d = S_WAIT_LOCK;
`endif
            end
         end
         S_FAULT: begin
            cnt_d = '0;
         end
         default: begin
            state_d = S_PLL_RST;
            cnt_d   = '0;
         end
      endcase
   end

   // State register with outputs registered from the state being entered.
   always_ff @(posedge clkin) begin
      if (reset) begin
         state_q     <= S_PLL_RST;
         cnt_q       <= '0;
         retry_q     <= '0;
         pll_reset_q <= 1'b1;
         sys_reset_q <= 1'b1;
         locked_q    <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         pll_reset_q <= (state_d == S_PLL_RST);
         sys_reset_q <= (state_d != S_RUN);
         locked_q    <= (state_d == S_RUN);
         fault_q     <= (state_d == S_FAULT);
      end
   end

   assign pll_reset   = pll_reset_q;
   assign sys_reset   = sys_reset_q;
   assign locked      = locked_q;
   assign fault       = fault_q;
   assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor with RST_PULSE_CYC=4,
// LOCK_TIMEOUT_CYC=20, LOCK_STABLE_CYC=8, MAX_RETRY=2. Inputs change and outputs
// are sampled on the falling clock edge. Latencies are counted in falling edges
// from the one where the stimulus is applied.
module tb_pll_lock_supervisor;

   localparam int LIM = 200;

   logic       clkin = 1'b0;
   logic       reset;
   logic       lock_in;
   logic       pll_reset;
   logic       sys_reset;
   logic       locked;
   logic       fault;
   logic [3:0] retry_count;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_retry = 0;

   typedef struct {
      string tag;
      int    val;
   } exp_t;

   exp_t sb_q[$];

   pll_lock_supervisor #(
      .RST_PULSE_CYC   (4),
      .LOCK_TIMEOUT_CYC(20),
      .LOCK_STABLE_CYC (8),
      .MAX_RETRY       (2)
   ) dut (
      .clkin      (clkin),
      .reset      (reset),
      .lock_in    (lock_in),
      .pll_reset  (pll_reset),
      .sys_reset  (sys_reset),
      .locked     (locked),
      .fault      (fault),
      .retry_count(retry_count)
   );

   always #5 clkin = ~clkin;

   task automatic check_val(input string tag, input int obs, input int exp_v);
      n_cmp++;
      if (obs != exp_v) begin
         n_bad++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic sb_push(input string tag, input int v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb_q.push_back(e);
   endtask

   task automatic sb_check(input int obs);
      exp_t e;
      if (sb_q.size() == 0) begin
         check_val("sb_underflow", sb_q.size(), 1);
      end else begin
         e = sb_q.pop_front();
         check_val(e.tag, obs, e.val);
      end
   endtask

   task automatic push_outs(input string pfx, input int p, input int s, input int l,
                            input int f, input int r);
      sb_push({pfx, ".pll_reset"}, p);
      sb_push({pfx, ".sys_reset"}, s);
      sb_push({pfx, ".locked"}, l);
      sb_push({pfx, ".fault"}, f);
      sb_push({pfx, ".retry_count"}, r);
   endtask

   task automatic check_outs();
      sb_check(int'(pll_reset));
      sb_check(int'(sys_reset));
      sb_check(int'(locked));
      sb_check(int'(fault));
      sb_check(int'(retry_count));
   endtask

   task automatic cyc();
      @(negedge clkin);
   endtask

   // Cycles pll_reset stays high, counting the current sample.
   task automatic meas_pll_high(output int n);
      n = 0;
      while (pll_reset && n < LIM) begin
         n++;
         cyc();
      end
   endtask

   // Cycles pll_reset stays low before the next pulse or the fault.
   task automatic meas_pll_gap(output int n);
      n = 0;
      while (!pll_reset && !fault && n < LIM) begin
         n++;
         cyc();
      end
   endtask

   task automatic meas_sys_low(output int n);
      n = 0;
      do begin
         cyc();
         n++;
      end while (sys_reset && n < LIM);
   endtask

   task automatic meas_sys_high(output int n);
      n = 0;
      do begin
         cyc();
         n++;
      end while (!sys_reset && n < LIM);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int k;
      reset   = 1'b1;
      lock_in = 1'b0;
      repeat (3) cyc();
      push_outs("rst", 1, 1, 0, 0, 0);
      check_outs();

      // Power-up: 4-cycle pulse, then lock 10 cycles after release.
      reset = 1'b0;
      sb_push("t1_pulse", 4);
      meas_pll_high(n);
      sb_check(n);
      repeat (6) cyc();
      lock_in = 1'b1;
      // 2 sync + 1 WAIT->STABLE + 8 stable cycles
      sb_push("t1_release_lat", 11);
      meas_sys_low(n);
      sb_check(n);
      push_outs("t1_run", 0, 0, 1, 0, 0);
      check_outs();

      // Loss of lock in RUN.
      lock_in = 1'b0;
      sb_push("t4_loss_lat", 3);
      meas_sys_high(n);
      sb_check(n);
`ifdef LOCK_LOSS_RECOVER_EN
      push_outs("t4_loss", 1, 1, 0, 0, 1);
      check_outs();
      sb_push("t4_pulse", 4);
      meas_pll_high(n);
      sb_check(n);
      exp_retry = 1;
`else
      push_outs("t4_loss", 0, 1, 0, 0, 0);
      check_outs();
      sb_push("t4_no_pulse", 0);
      k = 0;
      repeat (10) begin
         cyc();
         if (pll_reset) k++;
      end
      sb_check(k);
      exp_retry = 0;
`endif

      // Lock bounce in STABLE: 6 high, 3 low, then held high.
      lock_in = 1'b1;
      sb_push("t3_no_release", 0);
      k = 0;
      repeat (6) begin
         cyc();
         if (!sys_reset) k++;
      end
      lock_in = 1'b0;
      repeat (3) begin
         cyc();
         if (!sys_reset) k++;
      end
      sb_check(k);
      lock_in = 1'b1;
      sb_push("t3_release_lat", 11);
      sb_push("t3_retry", exp_retry);
      meas_sys_low(n);
      sb_check(n);
      sb_check(int'(retry_count));

      // Lock seen on the exact timeout cycle wins.
      lock_in = 1'b0;
      reset   = 1'b1;
      cyc();
      reset = 1'b0;
      sb_push("t5_pulse", 4);
      meas_pll_high(n);
      sb_check(n);
      repeat (17) cyc();
      lock_in = 1'b1;
      sb_push("t5_release_lat", 11);
      sb_push("t5_retry", 0);
      meas_sys_low(n);
      sb_check(n);
      sb_check(int'(retry_count));

      // One cycle later the timeout wins and a retry is issued.
      lock_in = 1'b0;
      reset   = 1'b1;
      cyc();
      reset = 1'b0;
      sb_push("t5b_pulse0", 4);
      meas_pll_high(n);
      sb_check(n);
      repeat (18) cyc();
      lock_in = 1'b1;
      sb_push("t5b_retry", 1);
      sb_push("t5b_pll_reset", 1);
      repeat (2) cyc();
      sb_check(int'(retry_count));
      sb_check(int'(pll_reset));
      sb_push("t5b_pulse1", 4);
      meas_pll_high(n);
      sb_check(n);

      // Reset while in STABLE restarts the whole sequence.
      repeat (2) cyc();
      reset = 1'b1;
      push_outs("t6_rst", 1, 1, 0, 0, 0);
      cyc();
      check_outs();
      reset = 1'b0;
      sb_push("t6_pulse", 4);
      sb_push("t6_release_lat", 9);
      meas_pll_high(n);
      sb_check(n);
      meas_sys_low(n);
      sb_check(n);

      // No lock at all: three attempts, then sticky fault.
      lock_in = 1'b0;
      reset   = 1'b1;
      cyc();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sb_push("t2_pulse", 4);
         sb_push("t2_gap", 20);
         meas_pll_high(n);
         sb_check(n);
         meas_pll_gap(n);
         sb_check(n);
      end
      push_outs("t2_fault", 0, 1, 0, 1, 2);
      check_outs();
      repeat (10) cyc();
      push_outs("t2_sticky", 0, 1, 0, 1, 2);
      check_outs();
      reset = 1'b1;
      push_outs("t2_clear", 1, 1, 0, 0, 0);
      cyc();
      check_outs();
      reset = 1'b0;

      check_val("sb_leftover", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
